// File: rtl/bram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// bram_mem_ctrl
// Memory-side controller for the cartridge backup RAM. Turns the cart front
// end's level strobes into single req/ack transactions on the shared external
// memory port, returns read data, and tracks which regions have been written.
//
// Optional feature macro: BRAM_DIRTY_MAP_EN
//   defined   : per-block dirty bitmap (64 blocks of 2**BLK_SHIFT bytes);
//               dirty = OR of the map
//   undefined : dirty_map tied to 0, single dirty flag only
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   size                : 0 = 128 KB cart (addr bit 17 forced 0), 1 = 256 KB
//   mem_addr/din        : byte address / write data from the front end
//   mem_oe              : read strobe (level)
//   mem_we_lo/hi        : byte write strobes (level)
//   mem_dout            : last read data
//   ram_addr/dati       : external address / write data
//   ram_we_lo/hi        : byte enables, both 0 = read
//   ram_req / ram_ack   : request level / one-cycle completion pulse
//   ram_dato            : external read data, valid with ram_ack
//   dirty, dirty_map    : write-tracking status
//   dirty_clr           : one-cycle pulse clearing all dirty state
// -----------------------------------------------------------------------------
module bram_mem_ctrl #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned BLK_SHIFT = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_din,
  input  logic              mem_oe,
  input  logic              mem_we_lo,
  input  logic              mem_we_hi,
  output logic [15:0]       mem_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dati,
  output logic              ram_we_lo,
  output logic              ram_we_hi,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [15:0]       ram_dato,
  output logic              dirty,
  input  logic              dirty_clr,
  output logic [63:0]       dirty_map
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } state_t;

  state_t r_state;

  // Edge-detect history; r_arm suppresses events in the first cycle after
  // reset so a strobe already high at release is not seen as an edge.
  logic r_arm;
  logic r_oe_q;
  logic r_we_q;

  // One-deep pending slot
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [1:0]        r_pend_we;
  logic              r_ovf;

  logic              w_we_any;
  logic              w_rd_ev;
  logic              w_wr_ev;
  logic              w_ev;
  logic [ADDR_W-1:0] w_cap_addr;
  logic [1:0]        w_cap_we;
  logic              w_issue;
  logic              w_wr_issue;
  logic              w_unused;

  assign w_we_any = mem_we_lo | mem_we_hi;
  assign w_rd_ev  = r_arm & mem_oe   & ~r_oe_q;
  assign w_wr_ev  = r_arm & w_we_any & ~r_we_q;
  assign w_ev     = w_rd_ev | w_wr_ev;

  // Word-aligned address; top bit masked for the 128 KB cart so it aliases.
  assign w_cap_addr = {(size & mem_addr[ADDR_W-1]), mem_addr[ADDR_W-2:1], 1'b0};
  // Write wins over a coincident read: enables come from the write strobes.
  assign w_cap_we   = w_wr_ev ? {mem_we_hi, mem_we_lo} : 2'b00;

  assign w_issue    = (r_state == S_IDLE) & r_pend_vld;
  assign w_wr_issue = w_issue & (|r_pend_we);

  // Overflow flag is debug-only and byte-select bit 0 is ignored by design.
  assign w_unused = ^{mem_addr[0], r_ovf};

  // Strobe edge detect and pending-slot capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm       <= 1'b0;
      r_oe_q      <= 1'b0;
      r_we_q      <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_pend_we   <= 2'b00;
      r_ovf       <= 1'b0;
    end else begin
      r_arm  <= 1'b1;
      r_oe_q <= mem_oe;
      r_we_q <= w_we_any;
      if (w_ev) begin
        // A new event replaces the slot; losing an unissued entry is overflow.
        r_pend_vld  <= 1'b1;
        r_pend_addr <= w_cap_addr;
        r_pend_data <= mem_din;
        r_pend_we   <= w_cap_we;
        if (r_pend_vld && !w_issue) begin
          r_ovf <= 1'b1;
        end
      end else if (w_issue) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Transaction FSM with registered external-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      ram_dati  <= '0;
      ram_we_lo <= 1'b0;
      ram_we_hi <= 1'b0;
      mem_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend_vld) begin
            ram_addr  <= r_pend_addr;
            ram_dati  <= r_pend_data;
            ram_we_lo <= r_pend_we[0];
            ram_we_hi <= r_pend_we[1];
            ram_req   <= 1'b1;
            r_state   <= (|r_pend_we) ? S_WR_WAIT : S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (ram_ack) begin
            mem_dout <= ram_dato;
            ram_req  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          ram_req <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Dirty tracking. A clear coinciding with a write issue wins for one cycle;
  // that write's mark is replayed the cycle after via r_mark_pend.
`ifdef BRAM_DIRTY_MAP_EN
  logic [63:0]      r_dirty_map;
  logic             r_mark_pend;
  logic [IDX_W-1:0] r_mark_idx;
  logic [IDX_W-1:0] w_blk_idx;

  assign w_blk_idx = IDX_W'(r_pend_addr >> BLK_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dirty_map <= '0;
      r_mark_pend <= 1'b0;
      r_mark_idx  <= '0;
    end else if (dirty_clr) begin
      r_dirty_map <= '0;
      r_mark_pend <= w_wr_issue;
      r_mark_idx  <= w_blk_idx;
    end else begin
      r_mark_pend <= 1'b0;
      if (w_wr_issue) begin
        r_dirty_map[w_blk_idx] <= 1'b1;
      end
      if (r_mark_pend) begin
        r_dirty_map[r_mark_idx] <= 1'b1;
      end
    end
  end

  assign dirty_map = r_dirty_map;
  assign dirty     = |r_dirty_map;
`else
  logic r_dirty;
  logic r_mark_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dirty     <= 1'b0;
      r_mark_pend <= 1'b0;
    end else if (dirty_clr) begin
      r_dirty     <= 1'b0;
      r_mark_pend <= w_wr_issue;
    end else begin
      r_mark_pend <= 1'b0;
      if (w_wr_issue || r_mark_pend) begin
        r_dirty <= 1'b1;
      end
    end
  end

  assign dirty_map = '0;
  assign dirty     = r_dirty;
`endif

endmodule

// File: tb/tb_bram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_mem_ctrl
// Scoreboard bench: each strobe pushes the expected external request (and the
// read data the responder will return); a monitor pops on every ram_req rise
// and checks address, data, enables, stability and returned read data.
// -----------------------------------------------------------------------------
module tb_bram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        size;
  logic [17:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_oe;
  logic        mem_we_lo;
  logic        mem_we_hi;
  logic [15:0] mem_dout;
  logic [17:0] ram_addr;
  logic [15:0] ram_dati;
  logic        ram_we_lo;
  logic        ram_we_hi;
  logic        ram_req;
  logic        ram_ack;
  logic [15:0] ram_dato;
  logic        dirty;
  logic        dirty_clr;
  logic [63:0] dirty_map;

  always #5 clk = ~clk;

  bram_mem_ctrl #(.ADDR_W(18), .BLK_SHIFT(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .size      (size),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_oe    (mem_oe),
    .mem_we_lo (mem_we_lo),
    .mem_we_hi (mem_we_hi),
    .mem_dout  (mem_dout),
    .ram_addr  (ram_addr),
    .ram_dati  (ram_dati),
    .ram_we_lo (ram_we_lo),
    .ram_we_hi (ram_we_hi),
    .ram_req   (ram_req),
    .ram_ack   (ram_ack),
    .ram_dato  (ram_dato),
    .dirty     (dirty),
    .dirty_clr (dirty_clr),
    .dirty_map (dirty_map)
  );

  typedef struct {
    logic [17:0] addr;
    logic [15:0] dati;
    logic [1:0]  we;
    logic [15:0] rdata;
  } req_t;

  req_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder (negedge) ----------------
  int   ack_dly  = 3;
  bit   resp_en  = 1'b1;
  bit   late_ack = 1'b0;
  int   r_cnt    = 0;
  req_t cur;
  bit   active   = 1'b0;

  initial begin
    ram_ack  = 1'b0;
    ram_dato = 16'h0;
    forever begin
      @(negedge clk);
      ram_ack = 1'b0;
      if (resp_en && ram_req) begin
        if (r_cnt >= ack_dly) begin
          ram_ack  = 1'b1;
          ram_dato = cur.rdata;
          r_cnt    = 0;
        end else begin
          r_cnt++;
        end
      end else begin
        r_cnt = 0;
      end
      if (late_ack) ram_ack = 1'b1;
    end
  end

  // ---------------- monitor (posedge + 2) ----------------
  int n_req    = 0;
  bit prev_req = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (active && ram_ack) begin
        if (cur.we == 2'b00) check("rd_data", 64'(mem_dout), 64'(cur.rdata));
        check("req_drop_after_ack", 64'(ram_req), 64'd0);
        active = 1'b0;
      end else if (active && !ram_req) begin
        active = 1'b0;
      end
      if (ram_req && !prev_req) begin
        n_req++;
        check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          cur    = sb_q.pop_front();
          active = 1'b1;
        end
      end
      if (ram_req && active) begin
        check("ram_addr", 64'(ram_addr), 64'(cur.addr));
        check("ram_dati", 64'(ram_dati), 64'(cur.dati));
        check("ram_we", 64'({ram_we_hi, ram_we_lo}), 64'(cur.we));
      end
      prev_req = ram_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] exp_addr(input logic [17:0] a, input logic sz);
    return {(sz & a[17]), a[16:1], 1'b0};
  endfunction

  task automatic push(input logic [17:0] a, input logic [15:0] d,
                      input logic [1:0] we, input logic [15:0] rd);
    req_t it;
    it.addr  = exp_addr(a, size);
    it.dati  = d;
    it.we    = we;
    it.rdata = rd;
    sb_q.push_back(it);
  endtask

  task automatic rd_strobe(input logic [17:0] a, input logic [15:0] d, input logic [15:0] rd);
    push(a, d, 2'b00, rd);
    mem_addr = a;
    mem_din  = d;
    mem_oe   = 1'b1;
    tick();
    mem_oe   = 1'b0;
  endtask

  task automatic wr_strobe(input logic [17:0] a, input logic [15:0] d,
                           input logic lo, input logic hi);
    push(a, d, {hi, lo}, 16'h0);
    mem_addr  = a;
    mem_din   = d;
    mem_we_lo = lo;
    mem_we_hi = hi;
    tick();
    mem_we_lo = 1'b0;
    mem_we_hi = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((ram_req || active || sb_q.size() != 0) && i < 200) begin
      tick();
      i++;
    end
    check({tag, "_timeout"}, 64'(i < 200), 64'd1);
    tick();
  endtask

  task automatic pulse_clr();
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int n0;

  initial begin
    rst       = 1'b1;
    size      = 1'b1;
    mem_addr  = 18'h0;
    mem_din   = 16'h0;
    mem_oe    = 1'b1;   // held high across reset release: must not be an event
    mem_we_lo = 1'b0;
    mem_we_hi = 1'b0;
    dirty_clr = 1'b0;
    repeat (3) tick();

    check("rst_req",   64'(ram_req), 64'd0);
    check("rst_we",    64'({ram_we_hi, ram_we_lo}), 64'd0);
    check("rst_addr",  64'(ram_addr), 64'd0);
    check("rst_dati",  64'(ram_dati), 64'd0);
    check("rst_dout",  64'(mem_dout), 64'd0);
    check("rst_dirty", 64'(dirty), 64'd0);
    check("rst_map",   dirty_map, 64'd0);

    rst = 1'b0;
    repeat (4) begin
      tick();
      check("rel_no_event", 64'(ram_req), 64'd0);
    end
    mem_oe = 1'b0;
    tick();

    // Read with ack 3 cycles after request
    ack_dly = 3;
    rd_strobe(18'h00100, 16'h0042, 16'hA55A);
    check("lat_slot_cycle", 64'(ram_req), 64'd0);
    tick();
    check("lat_req_cycle", 64'(ram_req), 64'd1);
    wait_idle("rd");
    check("rd_dout", 64'(mem_dout), 64'hA55A);
    repeat (5) tick();
    check("dout_hold", 64'(mem_dout), 64'hA55A);
    check("rd_not_dirty", 64'(dirty), 64'd0);

    // High-byte write
    wr_strobe(18'h01234, 16'hBEEF, 1'b0, 1'b1);
    wait_idle("bwr");
    check("bwr_dirty", 64'(dirty), 64'd1);
`ifdef BRAM_DIRTY_MAP_EN
    check("bwr_map", dirty_map, 64'h2);
`else
    check("bwr_map", dirty_map, 64'd0);
`endif

    // 128 KB alias
    pulse_clr();
    check("clr_dirty", 64'(dirty), 64'd0);
    check("clr_map", dirty_map, 64'd0);
    size = 1'b0;
    wr_strobe(18'h20010, 16'h1111, 1'b1, 1'b1);
    wait_idle("alias");
    check("alias_dirty", 64'(dirty), 64'd1);
`ifdef BRAM_DIRTY_MAP_EN
    check("alias_map", dirty_map, 64'h1);
`else
    check("alias_map", dirty_map, 64'd0);
`endif
    size = 1'b1;

    // Read queued behind a slow write
    pulse_clr();
    ack_dly = 5;
    n0 = n_req;
    wr_strobe(18'h3F000, 16'hC0DE, 1'b1, 1'b1);
    tick();
    tick();
    check("q_in_wr_wait", 64'(ram_req), 64'd1);
    rd_strobe(18'h00200, 16'h0000, 16'h5A5A);
    wait_idle("queue");
    check("q_two_reqs", 64'(n_req - n0), 64'd2);
    check("q_dout", 64'(mem_dout), 64'h5A5A);
    check("q_dirty", 64'(dirty), 64'd1);
`ifdef BRAM_DIRTY_MAP_EN
    check("q_map", dirty_map, 64'h8000_0000_0000_0000);
`else
    check("q_map", dirty_map, 64'd0);
`endif

    // Read and write rising together: only the write is issued
    ack_dly = 2;
    n0 = n_req;
    push(18'h00400, 16'h7777, 2'b01, 16'h0);
    mem_addr  = 18'h00400;
    mem_din   = 16'h7777;
    mem_oe    = 1'b1;
    mem_we_lo = 1'b1;
    tick();
    mem_oe    = 1'b0;
    mem_we_lo = 1'b0;
    wait_idle("both");
    check("both_one_req", 64'(n_req - n0), 64'd1);
    check("both_dout_kept", 64'(mem_dout), 64'h5A5A);

    // dirty_clr coincident with write issue
    check("pre_clr_dirty", 64'(dirty), 64'd1);
    wr_strobe(18'h00500, 16'h2222, 1'b1, 1'b0);
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    check("ci_req", 64'(ram_req), 64'd1);
    check("ci_dirty_low", 64'(dirty), 64'd0);
    tick();
    check("ci_dirty_high", 64'(dirty), 64'd1);
`ifdef BRAM_DIRTY_MAP_EN
    check("ci_map", dirty_map, 64'h1);
`else
    check("ci_map", dirty_map, 64'd0);
`endif
    wait_idle("ci");

    // Reset during RD_WAIT, then a late ack
    resp_en = 1'b0;
    rd_strobe(18'h00300, 16'h0000, 16'h1234);
    tick();
    tick();
    check("rr_req_high", 64'(ram_req), 64'd1);
    rst = 1'b1;
    tick();
    check("rr_req_drop", 64'(ram_req), 64'd0);
    check("rr_dout", 64'(mem_dout), 64'd0);
    check("rr_dirty", 64'(dirty), 64'd0);
    check("rr_map", dirty_map, 64'd0);
    rst = 1'b0;
    tick();
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    tick();
    tick();
    check("late_req", 64'(ram_req), 64'd0);
    check("late_dout", 64'(mem_dout), 64'd0);
    check("late_addr", 64'(ram_addr), 64'd0);
    resp_en = 1'b1;

    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
